// File: rtl/instr_encoder_loader_pkg.sv
// rtl/instr_encoder_loader_pkg.sv - op-select codes, MIPS opcode/funct constants, FSM states, field packers
// Build option: INSTR_ENC_PSEUDO_EN adds the S_WR_HI state used by the LI pseudo-instruction.
package instr_encoder_loader_pkg;

    // Loader op-select codes presented on in_op
    typedef enum logic [4:0] {
        OP_ADD   = 5'd0,
        OP_ADDU  = 5'd1,
        OP_SUB   = 5'd2,
        OP_SUBU  = 5'd3,
        OP_SLL   = 5'd4,
        OP_SRL   = 5'd5,
        OP_SLT   = 5'd6,
        OP_AND   = 5'd7,
        OP_OR    = 5'd8,
        OP_ADDIU = 5'd9,
        OP_BEQ   = 5'd10,
        OP_BNE   = 5'd11,
        OP_SLTI  = 5'd12,
        OP_ORI   = 5'd13,
        OP_LW    = 5'd14,
        OP_LUI   = 5'd15,
        OP_SW    = 5'd16,
        OP_J     = 5'd17,
        OP_LI    = 5'd18
    } op_e;

    // R-type funct field values
    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_ADDU = 6'h21;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_SUBU = 6'h23;
    localparam logic [5:0] FUNCT_SLL  = 6'h00;
    localparam logic [5:0] FUNCT_SRL  = 6'h02;
    localparam logic [5:0] FUNCT_SLT  = 6'h2A;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;

    // Primary opcode field values
    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_BNE   = 6'h05;
    localparam logic [5:0] OPC_ADDIU = 6'h09;
    localparam logic [5:0] OPC_SLTI  = 6'h0A;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_LUI   = 6'h0F;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WR    = 2'd1,
`ifdef INSTR_ENC_PSEUDO_EN
        S_WR_HI = 2'd2,
`endif
        S_FULL  = 2'd3
    } state_e;

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] shamt,
                                          input logic [5:0] funct);
        return {OPC_RTYPE, rs, rt, rd, shamt, funct};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] opc, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {opc, rs, rt, imm};
    endfunction

endpackage

// File: rtl/instr_word_builder.sv
// rtl/instr_word_builder.sv - combinational op + operand fields to 32-bit MIPS word
// Build option: INSTR_ENC_PSEUDO_EN makes op LI legal (o_word = LUI half, o_word_hi = ORI half).
// Ports:
//  i_op                      op-select code
//  i_rs/i_rt/i_rd/i_shamt    register and shift fields
//  i_imm                     immediate (low half for I-type, full value for LI)
//  i_target                  raw J target field
//  o_word                    first (or only) encoded word
//  o_word_hi                 ORI rt,rt,imm[15:0] second word of LI
//  o_legal                   op code is encodable
//  o_is_li                   op is the two-word LI pseudo-instruction
module instr_word_builder
    import instr_encoder_loader_pkg::*;
(
    input  logic [4:0]  i_op,
    input  logic [4:0]  i_rs,
    input  logic [4:0]  i_rt,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_shamt,
    input  logic [31:0] i_imm,
    input  logic [25:0] i_target,
    output logic [31:0] o_word,
    output logic [31:0] o_word_hi,
    output logic        o_legal,
    output logic        o_is_li
);

    assign o_word_hi = enc_i(OPC_ORI, i_rt, i_rt, i_imm[15:0]);

    // Shifts take their operand from rt, so rs is zeroed; other R-types zero shamt.
    always_comb begin
        o_word  = '0;
        o_legal = 1'b1;
        o_is_li = 1'b0;
        case (i_op)
            OP_ADD:   o_word = enc_r(i_rs, i_rt, i_rd, 5'd0, FUNCT_ADD);
            OP_ADDU:  o_word = enc_r(i_rs, i_rt, i_rd, 5'd0, FUNCT_ADDU);
            OP_SUB:   o_word = enc_r(i_rs, i_rt, i_rd, 5'd0, FUNCT_SUB);
            OP_SUBU:  o_word = enc_r(i_rs, i_rt, i_rd, 5'd0, FUNCT_SUBU);
            OP_SLL:   o_word = enc_r(5'd0, i_rt, i_rd, i_shamt, FUNCT_SLL);
            OP_SRL:   o_word = enc_r(5'd0, i_rt, i_rd, i_shamt, FUNCT_SRL);
            OP_SLT:   o_word = enc_r(i_rs, i_rt, i_rd, 5'd0, FUNCT_SLT);
            OP_AND:   o_word = enc_r(i_rs, i_rt, i_rd, 5'd0, FUNCT_AND);
            OP_OR:    o_word = enc_r(i_rs, i_rt, i_rd, 5'd0, FUNCT_OR);
            OP_ADDIU: o_word = enc_i(OPC_ADDIU, i_rs, i_rt, i_imm[15:0]);
            OP_BEQ:   o_word = enc_i(OPC_BEQ, i_rs, i_rt, i_imm[15:0]);
            OP_BNE:   o_word = enc_i(OPC_BNE, i_rs, i_rt, i_imm[15:0]);
            OP_SLTI:  o_word = enc_i(OPC_SLTI, i_rs, i_rt, i_imm[15:0]);
            OP_ORI:   o_word = enc_i(OPC_ORI, i_rs, i_rt, i_imm[15:0]);
            OP_LW:    o_word = enc_i(OPC_LW, i_rs, i_rt, i_imm[15:0]);
            OP_LUI:   o_word = enc_i(OPC_LUI, 5'd0, i_rt, i_imm[15:0]);
            OP_SW:    o_word = enc_i(OPC_SW, i_rs, i_rt, i_imm[15:0]);
            OP_J:     o_word = {OPC_J, i_target};
`ifdef INSTR_ENC_PSEUDO_EN
            OP_LI: begin
                o_word  = enc_i(OPC_LUI, 5'd0, i_rt, i_imm[31:16]);
                o_is_li = 1'b1;
            end
`endif
            default:  o_legal = 1'b0;
        endcase
    end

`ifndef INSTR_ENC_PSEUDO_EN
    logic w_unused_imm_hi;
    assign w_unused_imm_hi = ^i_imm[31:16];
`endif

endmodule

// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - encodes mnemonic+fields into MIPS words and writes them sequentially to IMEM
// Build option: INSTR_ENC_PSEUDO_EN enables LI (LUI then ORI on consecutive cycles); otherwise op 18 is illegal.
// Ports:
//  clk, rst            clock, synchronous active-high reset
//  clr                 restart write pointer at BASE_ADDR and clear flags
//  in_valid/in_ready   request handshake
//  in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target   mnemonic and operand fields
//  imem_we/imem_addr/imem_wdata   IMEM write port (registered, one cycle after accept)
//  word_count          words written since rst/clr
//  full                last address has been written
//  err_illegal         sticky: an unencodable op was accepted and dropped
module instr_encoder_loader
    import instr_encoder_loader_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [31:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              full,
    output logic              err_illegal
);

    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);

    state_e            r_state;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [ADDR_W:0]   r_count;
    logic              r_full;
    logic              r_err;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_done;   // last slot consumed; blocks requests until S_FULL is reached

    logic [31:0] w_word;
    logic [31:0] w_word_hi;
    logic        w_legal;
    logic        w_is_li;
    logic        w_hold;
    logic        w_accept;
    logic        w_issue;
    logic [31:0] w_issue_word;

    instr_word_builder u_builder (
        .i_op     (in_op),
        .i_rs     (in_rs),
        .i_rt     (in_rt),
        .i_rd     (in_rd),
        .i_shamt  (in_shamt),
        .i_imm    (in_imm),
        .i_target (in_target),
        .o_word   (w_word),
        .o_word_hi(w_word_hi),
        .o_legal  (w_legal),
        .o_is_li  (w_is_li)
    );

`ifdef INSTR_ENC_PSEUDO_EN
    logic [31:0] r_word_hi;
    assign w_hold = (r_state == S_WR_HI);
`else
    logic w_unused_li;
    assign w_hold      = 1'b0;
    assign w_unused_li = ^{w_word_hi, w_is_li};
`endif

    assign in_ready = !rst && !clr && !r_full && !r_done && !w_hold;
    assign w_accept = in_valid && in_ready;

    // A write is issued either for a legal accepted op or for the pending LI low half.
    always_comb begin
        w_issue      = 1'b0;
        w_issue_word = w_word;
        if (w_accept && w_legal) begin
            w_issue = 1'b1;
        end
`ifdef INSTR_ENC_PSEUDO_EN
        if (r_state == S_WR_HI) begin
            w_issue      = 1'b1;
            w_issue_word = r_word_hi;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_addr  <= BASE;
            r_wdata <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_err   <= 1'b0;
            r_ptr   <= BASE;
            r_done  <= 1'b0;
`ifdef INSTR_ENC_PSEUDO_EN
            r_word_hi <= '0;
`endif
        end else begin
            r_we <= w_issue;
            if (w_issue) begin
                r_addr  <= r_ptr;
                r_wdata <= w_issue_word;
                r_count <= r_count + CNT_ONE;
                // Pointer saturates on the last slot instead of wrapping.
                if (r_ptr == LAST_ADDR) begin
                    r_done <= 1'b1;
                end else begin
                    r_ptr <= r_ptr + PTR_ONE;
                end
            end
            if (w_accept && !w_legal) begin
                r_err <= 1'b1;
            end
            case (r_state)
                S_IDLE, S_WR: begin
                    if (w_issue) begin
                        r_state <= S_WR;
                    end else if (r_done) begin
                        r_state <= S_FULL;
                        r_full  <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
`ifdef INSTR_ENC_PSEUDO_EN
                    // LI needs two slots; with only one left the ORI half is dropped and flagged.
                    if (w_accept && w_is_li) begin
                        if (r_ptr != LAST_ADDR) begin
                            r_state   <= S_WR_HI;
                            r_word_hi <= w_word_hi;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
`endif
                end
`ifdef INSTR_ENC_PSEUDO_EN
                S_WR_HI: r_state <= S_WR;
`endif
                default: r_state <= S_FULL;
            endcase
        end
    end

    // rst/clr mask a write already on the port so a cancelled op never reaches IMEM.
    assign imem_we     = r_we && !rst && !clr;
    assign imem_addr   = r_addr;
    assign imem_wdata  = r_wdata;
    assign word_count  = r_count;
    assign full        = r_full;
    assign err_illegal = r_err;

endmodule
